// File: rtl/mem_bus_pkg.sv
// Shared types and helpers for the memory bus unit: access sizes, FSM states,
// byte-enable mask generation and alignment checking.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  // Mask is computed for up to 8 lanes; callers keep the low XLEN/8 bits.
  function automatic logic [7:0] be_mask(input size_e size, input logic [2:0] lane);
    logic [7:0] ones;
    case (size)
      SZ_B:    ones = 8'h01;
      SZ_H:    ones = 8'h03;
      SZ_W:    ones = 8'h0F;
      default: ones = 8'hFF;
    endcase
    return ones << lane;
  endfunction

  function automatic logic misaligned(input size_e size, input logic [2:0] lo,
                                      input logic dword_ok);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = lo[0];
      SZ_W:    bad = |lo[1:0];
      default: bad = !dword_ok || (|lo);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane handling: extracts and sign/zero-extends load data from the
// addressed byte lane, and replicates store data across all lanes of its size.
module mem_lane_align
  import mem_bus_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rd_data,
  input  logic [2:0]      rd_lane,
  input  logic [1:0]      rd_size,
  input  logic            rd_signed,
  output logic [XLEN-1:0] ld_data,
  output logic [31:0]     instr,
  input  logic [1:0]      st_size,
  input  logic [XLEN-1:0] st_raw,
  output logic [XLEN-1:0] st_data
);

  logic [XLEN-1:0] shifted;

  assign shifted = rd_data >> {rd_lane, 3'b000};
  assign instr   = shifted[31:0];

  // Fill with the extension bit first, then overlay the payload; this avoids
  // zero-width replication when the payload is already XLEN wide.
  always_comb begin
    ld_data = shifted;
    case (size_e'(rd_size))
      SZ_B: begin
        ld_data      = {XLEN{rd_signed & shifted[7]}};
        ld_data[7:0] = shifted[7:0];
      end
      SZ_H: begin
        ld_data       = {XLEN{rd_signed & shifted[15]}};
        ld_data[15:0] = shifted[15:0];
      end
      SZ_W: begin
        ld_data       = {XLEN{rd_signed & shifted[31]}};
        ld_data[31:0] = shifted[31:0];
      end
      default: ld_data = shifted;
    endcase
  end

  always_comb begin
    st_data = st_raw;
    case (size_e'(st_size))
      SZ_B:    st_data = {(XLEN/8){st_raw[7:0]}};
      SZ_H:    st_data = {(XLEN/16){st_raw[15:0]}};
      SZ_W:    st_data = {(XLEN/32){st_raw[31:0]}};
      default: st_data = st_raw;
    endcase
  end

endmodule

// File: rtl/mem_bus_unit.sv
// Memory bus unit: owns MAR/MDR/IR and the single-outstanding memory handshake.
// Optional BUS_TIMEOUT_EN adds a wait-state limit that ends ACCESS with an error.
module mem_bus_unit
  import mem_bus_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned ALEN        = 32,
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic              iClk,
  input  logic              nRst,
  input  logic              iReqValid,
  output logic              oReqReady,
  input  logic              iReqFetch,
  input  logic              iReqWrite,
  input  logic [1:0]        iReqSize,
  input  logic              iReqSigned,
  input  logic [ALEN-1:0]   iReqAddr,
  input  logic [XLEN-1:0]   iReqWData,
  output logic              oRspValid,
  output logic              oRspErr,
  output logic [XLEN-1:0]   oRspData,
  output logic [31:0]       oInstr,
  output logic [ALEN-1:0]   oMemAddr,
  output logic [XLEN-1:0]   oMemData,
  output logic [XLEN/8-1:0] oMemByteEn,
  output logic              oMemRead,
  output logic              oMemWrite,
  input  logic [XLEN-1:0]   iMemData,
  input  logic              iMemReady
);

  localparam int unsigned NB = XLEN / 8;
  localparam int unsigned LB = $clog2(NB);

  state_e state_q, state_d;

  logic [2:0]      req_lane;
  size_e           req_size;
  logic            req_write;
  logic            req_err;
  logic            accept;
  logic [7:0]      req_be;
  logic [ALEN-1:0] req_mar;

  logic [2:0]      lane_q;
  logic [1:0]      size_q;
  logic            signed_q;
  logic            fetch_q;
  logic            write_q;
  logic            err_q;
  logic [ALEN-1:0] mar_q;
  logic [XLEN-1:0] mdr_q;
  logic [31:0]     ir_q;
  logic [XLEN-1:0] mem_data_q;
  logic [NB-1:0]   be_q;

  logic [XLEN-1:0] ld_data;
  logic [31:0]     instr;
  logic [XLEN-1:0] st_data;
  logic            mem_done;
  logic            timeout;

  always_comb begin
    req_lane         = '0;
    req_lane[LB-1:0] = iReqAddr[LB-1:0];
    req_mar          = iReqAddr;
    req_mar[LB-1:0]  = '0;
  end

  assign req_size  = iReqFetch ? SZ_W : size_e'(iReqSize);
  assign req_write = !iReqFetch && iReqWrite;
  assign req_err   = misaligned(req_size, req_lane, XLEN == 64);
  assign req_be    = be_mask(req_size, req_lane);
  assign accept    = iReqValid && (state_q == IDLE);
  assign mem_done  = (state_q == ACCESS) && iMemReady;

  mem_lane_align #(.XLEN(XLEN)) u_align (
    .rd_data   (iMemData),
    .rd_lane   (lane_q),
    .rd_size   (size_q),
    .rd_signed (signed_q),
    .ld_data   (ld_data),
    .instr     (instr),
    .st_size   (req_size),
    .st_raw    (iReqWData),
    .st_data   (st_data)
  );

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYC + 1);

  logic [WAIT_W-1:0] wait_q;

  assign timeout = (state_q == ACCESS) && !iMemReady
                   && (wait_q == WAIT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      wait_q <= '0;
    end else if (accept) begin
      wait_q <= '0;
    end else if ((state_q == ACCESS) && !iMemReady) begin
      wait_q <= wait_q + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = req_err ? RESP : ACCESS;
      ACCESS:  if (iMemReady || timeout) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    oReqReady = (state_q == IDLE);
    oRspValid = (state_q == RESP);
    oRspErr   = (state_q == RESP) && err_q;
    oMemRead  = (state_q == ACCESS) && !write_q;
    oMemWrite = (state_q == ACCESS) && write_q;
  end

  // Request attributes latched once per accepted request.
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      lane_q   <= '0;
      size_q   <= '0;
      signed_q <= 1'b0;
      fetch_q  <= 1'b0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
    end else if (accept) begin
      lane_q   <= req_lane;
      size_q   <= req_size;
      signed_q <= iReqSigned;
      fetch_q  <= iReqFetch;
      write_q  <= req_write;
      err_q    <= req_err;
    end else if (timeout) begin
      err_q    <= 1'b1;
    end
  end

  // MAR, store data and lane enables only change on a request that reaches memory.
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      mar_q      <= '0;
      mem_data_q <= '0;
      be_q       <= '0;
    end else if (accept && !req_err) begin
      mar_q      <= req_mar;
      mem_data_q <= st_data;
      be_q       <= req_write ? req_be[NB-1:0] : '1;
    end
  end

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      mdr_q <= '0;
      ir_q  <= '0;
    end else if (mem_done && !write_q) begin
      if (fetch_q) ir_q  <= instr;
      else         mdr_q <= ld_data;
    end
  end

  assign oRspData   = mdr_q;
  assign oInstr     = ir_q;
  assign oMemAddr   = mar_q;
  assign oMemData   = mem_data_q;
  assign oMemByteEn = be_q;

endmodule

// File: tb/tb_mem_bus_unit.sv
// Directed self-checking bench for mem_bus_unit (XLEN=32); the timeout section
// is active only when BUS_TIMEOUT_EN is defined.
module tb_mem_bus_unit;

  logic        iClk;
  logic        nRst;
  logic        iReqValid;
  logic        oReqReady;
  logic        iReqFetch;
  logic        iReqWrite;
  logic [1:0]  iReqSize;
  logic        iReqSigned;
  logic [31:0] iReqAddr;
  logic [31:0] iReqWData;
  logic        oRspValid;
  logic        oRspErr;
  logic [31:0] oRspData;
  logic [31:0] oInstr;
  logic [31:0] oMemAddr;
  logic [31:0] oMemData;
  logic [3:0]  oMemByteEn;
  logic        oMemRead;
  logic        oMemWrite;
  logic [31:0] iMemData;
  logic        iMemReady;

  int total = 0;
  int bad   = 0;

  mem_bus_unit #(.XLEN(32), .ALEN(32), .TIMEOUT_CYC(15)) dut (
    .iClk       (iClk),
    .nRst       (nRst),
    .iReqValid  (iReqValid),
    .oReqReady  (oReqReady),
    .iReqFetch  (iReqFetch),
    .iReqWrite  (iReqWrite),
    .iReqSize   (iReqSize),
    .iReqSigned (iReqSigned),
    .iReqAddr   (iReqAddr),
    .iReqWData  (iReqWData),
    .oRspValid  (oRspValid),
    .oRspErr    (oRspErr),
    .oRspData   (oRspData),
    .oInstr     (oInstr),
    .oMemAddr   (oMemAddr),
    .oMemData   (oMemData),
    .oMemByteEn (oMemByteEn),
    .oMemRead   (oMemRead),
    .oMemWrite  (oMemWrite),
    .iMemData   (iMemData),
    .iMemReady  (iMemReady)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  // Presents one request for a single edge; returns #1 after the accepting edge.
  task automatic req(input logic f, input logic w, input logic [1:0] sz,
                     input logic sg, input logic [31:0] a, input logic [31:0] wd);
    iReqFetch  = f;
    iReqWrite  = w;
    iReqSize   = sz;
    iReqSigned = sg;
    iReqAddr   = a;
    iReqWData  = wd;
    iReqValid  = 1'b1;
    tick();
    iReqValid  = 1'b0;
  endtask

  initial begin
    nRst = 1'b0; iReqValid = 1'b0; iReqFetch = 1'b0; iReqWrite = 1'b0;
    iReqSize = 2'd0; iReqSigned = 1'b0; iReqAddr = '0; iReqWData = '0;
    iMemData = '0; iMemReady = 1'b0;

    tick();
    tick();
    chk("rst_ready",  oReqReady, 1'b1);
    chk("rst_rspv",   oRspValid, 1'b0);
    chk("rst_addr",   oMemAddr, 32'h0);
    chk("rst_mdr",    oRspData, 32'h0);
    chk("rst_ir",     oInstr, 32'h0);
    chk("rst_strobe", {oMemRead, oMemWrite}, 2'b00);
    chk("rst_be",     oMemByteEn, 4'h0);
    chk("rst_wdata",  oMemData, 32'h0);
    nRst = 1'b1;
    tick();

    // Zero-wait word load; iMemReady high while idle must be ignored.
    iMemReady = 1'b1;
    iMemData  = 32'hDEADBEEF;
    tick();
    chk("idle_ready_ign", oRspValid, 1'b0);
    req(1'b0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    chk("lw_read",   {oMemRead, oMemWrite}, 2'b10);
    chk("lw_addr",   oMemAddr, 32'h100);
    chk("lw_be",     oMemByteEn, 4'b1111);
    chk("lw_busy",   {oReqReady, oRspValid}, 2'b00);
    tick();
    chk("lw_rsp",    {oRspValid, oRspErr}, 2'b10);
    chk("lw_data",   oRspData, 32'hDEADBEEF);
    chk("lw_rsp_st", {oMemRead, oMemWrite, oReqReady}, 3'b000);
    tick();
    chk("lw_idle",   {oRspValid, oReqReady}, 2'b01);

    // Byte/half loads from lane data 0x80112233.
    iMemData = 32'h80112233;
    req(1'b0, 1'b0, 2'd0, 1'b1, 32'h103, 32'h0);
    chk("lb_be",   oMemByteEn, 4'b1111);
    chk("lb_addr", oMemAddr, 32'h100);
    tick();
    chk("lb_s",    oRspData, 32'hFFFFFF80);
    tick();
    req(1'b0, 1'b0, 2'd0, 1'b0, 32'h103, 32'h0);
    tick();
    chk("lbu",     oRspData, 32'h00000080);
    tick();
    req(1'b0, 1'b0, 2'd1, 1'b1, 32'h102, 32'h0);
    tick();
    chk("lh_s",    oRspData, 32'hFFFF8011);
    tick();
    req(1'b0, 1'b0, 2'd0, 1'b0, 32'h101, 32'h0);
    tick();
    chk("lbu_l1",  oRspData, 32'h00000022);
    tick();

    // Half store with 3 wait states; a request offered mid-access is dropped.
    iMemReady = 1'b0;
    req(1'b0, 1'b1, 2'd1, 1'b0, 32'h202, 32'h0000ABCD);
    chk("sh_addr",  oMemAddr, 32'h200);
    chk("sh_data",  oMemData, 32'hABCDABCD);
    chk("sh_be",    oMemByteEn, 4'b1100);
    chk("sh_write", {oMemRead, oMemWrite}, 2'b01);
    iReqValid = 1'b1;
    iReqAddr  = 32'h500;
    tick();
    chk("sh_wait1", {oRspValid, oMemWrite}, 2'b01);
    tick();
    chk("sh_wait2", {oRspValid, oMemWrite}, 2'b01);
    chk("sh_ignore_addr", oMemAddr, 32'h200);
    iReqValid = 1'b0;
    tick();
    chk("sh_wait3", {oRspValid, oMemWrite}, 2'b01);
    iMemReady = 1'b1;
    tick();
    chk("sh_rsp",   {oRspValid, oRspErr}, 2'b10);
    chk("sh_mdr",   oRspData, 32'h00000022);
    tick();
    chk("sh_idle",  oReqReady, 1'b1);

    req(1'b0, 1'b1, 2'd0, 1'b0, 32'h001, 32'h1234565A);
    chk("sb_data",  oMemData, 32'h5A5A5A5A);
    chk("sb_be",    oMemByteEn, 4'b0010);
    chk("sb_addr",  oMemAddr, 32'h0);
    tick();
    tick();

    // Misaligned / illegal requests answer next cycle with no strobe.
    req(1'b0, 1'b0, 2'd2, 1'b0, 32'h101, 32'h0);
    chk("mis_w_rsp",    {oRspValid, oRspErr}, 2'b11);
    chk("mis_w_strobe", {oMemRead, oMemWrite}, 2'b00);
    chk("mis_w_mdr",    oRspData, 32'h00000022);
    tick();
    req(1'b0, 1'b1, 2'd1, 1'b0, 32'h103, 32'h0);
    chk("mis_h_rsp",    {oRspValid, oRspErr, oMemWrite}, 3'b110);
    tick();
    req(1'b0, 1'b0, 2'd3, 1'b0, 32'h0, 32'h0);
    chk("dword_illegal", {oRspValid, oRspErr, oMemRead}, 3'b110);
    tick();

    // Fetch: forced word read, result goes to IR only.
    iMemData = 32'h00A00093;
    req(1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
    chk("f_read", {oMemRead, oMemWrite}, 2'b10);
    tick();
    chk("f_rsp",  {oRspValid, oRspErr}, 2'b10);
    chk("f_ir",   oInstr, 32'h00A00093);
    chk("f_mdr",  oRspData, 32'h00000022);
    tick();
    iMemData = 32'h12345678;
    req(1'b1, 1'b1, 2'd0, 1'b1, 32'h4, 32'h0);
    chk("f2_read", {oMemRead, oMemWrite, oMemByteEn}, 6'b10_1111);
    tick();
    chk("f2_ir",   oInstr, 32'h12345678);
    tick();

    // Reset while in ACCESS: strobes fall without a clock edge, no response.
    iMemReady = 1'b0;
    req(1'b0, 1'b0, 2'd2, 1'b0, 32'h300, 32'h0);
    chk("ra_read", oMemRead, 1'b1);
    nRst = 1'b0;
    #1;
    chk("ra_strobe", {oMemRead, oMemWrite}, 2'b00);
    chk("ra_ready",  oReqReady, 1'b1);
    chk("ra_mdr",    oRspData, 32'h0);
    #2;
    nRst = 1'b1;
    iMemReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ra_no_rsp", {oRspValid, oMemRead}, 2'b00);
    end

`ifdef BUS_TIMEOUT_EN
    iMemReady = 1'b0;
    iMemData  = 32'hCAFEF00D;
    req(1'b0, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    for (int i = 0; i < 14; i++) begin
      chk("to_waiting", {oRspValid, oMemRead}, 2'b01);
      tick();
    end
    chk("to_last_wait", {oRspValid, oMemRead}, 2'b01);
    tick();
    chk("to_rsp", {oRspValid, oRspErr, oMemRead}, 3'b110);
    chk("to_mdr", oRspData, 32'h0);
    tick();
    chk("to_idle", oReqReady, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
